imem_boot_ctrl: RTL and testbench

Boot-load sequencer for the instruction memory.
- After a start pulse, accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes those words into the instruction memory write port and checks an 8-bit checksum.
- Holds the CPU in reset until a load completes cleanly.
- Sits between the host byte source (UART RX / testbench) and the imem write port plus the core reset input.

---
 rtl/imem_boot_ctrl_pkg.sv | 23 ++
 rtl/boot_word_asm.sv | 52 +++++
 rtl/imem_boot_ctrl.sv | 138 +++++++++++++
 tb/tb_imem_boot_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The memory and the core import IMEM_W_DEFAULT so all three agree on the address width.
package imem_boot_ctrl_pkg;

  localparam int IMEM_W_DEFAULT = 13;
  localparam int BOOT_LEN_BYTES = 2;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CHK,
    DONE,
    ERR
  } boot_state_e;

  // Number of 32-bit words the instruction memory can hold.
  function automatic int imem_capacity_words(input int imem_w);
    return 1 << (imem_w - 2);
  endfunction

endpackage

// File: rtl/boot_word_asm.sv
// Assembles little-endian 32-bit words from a byte stream.
// Also keeps the mod-256 sum of every byte it has taken in.
module boot_word_asm (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_en,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [7:0]  sum
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  sum_q, sum_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
    shift_d = shift_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    if (clear) begin
      shift_d = '0;
      idx_d   = '0;
      sum_d   = '0;
    end else if (byte_en) begin
      // Newest byte enters at the top, so after four bytes byte 0 sits in the LSBs.
      shift_d = {byte_in, shift_q[23:8]};
      idx_d   = idx_q + 2'd1;
      sum_d   = sum_q + byte_in;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      shift_q <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

  assign word       = {byte_in, shift_q};
  assign word_valid = byte_en && !clear && (idx_q == 2'd3);
  assign sum        = sum_q;

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot-load sequencer: takes a length-prefixed, checksummed byte stream, writes the words
// into instruction memory and releases the CPU reset only after a clean load.
module imem_boot_ctrl
  import imem_boot_ctrl_pkg::*;
#(
  parameter int IMEM_W = IMEM_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              we,
  output logic [IMEM_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IMEM_W-2:0] word_cnt
);

  localparam int CNT_W = IMEM_W - 1;
  localparam int LEN_W = 8 * BOOT_LEN_BYTES;
  localparam logic [LEN_W:0] CAPACITY = (LEN_W + 1)'(imem_capacity_words(IMEM_W));

  boot_state_e       state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  n_q, n_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              we_q, we_d;
  logic [IMEM_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              accept;
  logic              start_ok;
  logic [LEN_W-1:0]  len_full;
  logic              last_word;
  logic              byte_en;
  logic [31:0]       asm_word;
  logic              asm_word_valid;
  logic [7:0]        asm_sum;

  assign accept    = rx_valid && rx_ready;
  assign start_ok  = start && (state_q inside {IDLE, DONE, ERR});
  assign len_full  = {rx_data, len_lo_q};
  assign last_word = (32'(word_cnt_q) + 32'd1) == 32'(n_q);
  assign byte_en   = accept && (state_q == DATA);

  boot_word_asm u_word_asm (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .byte_in   (rx_data),
    .byte_en   (byte_en),
    .word      (asm_word),
    .word_valid(asm_word_valid),
    .sum       (asm_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: if (start_ok) state_d = LEN0;
      LEN0: if (accept) state_d = LEN1;
      LEN1: begin
        if (accept) begin
          if ({1'b0, len_full} > CAPACITY) state_d = ERR;
          else if (len_full == '0)         state_d = CHK;
          else                             state_d = DATA;
        end
      end
      DATA: if (asm_word_valid && last_word) state_d = CHK;
      CHK:  if (accept) state_d = (rx_data == asm_sum) ? DONE : ERR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_ready = state_q inside {LEN0, LEN1, DATA, CHK};
    busy     = state_q inside {LEN0, LEN1, DATA, CHK};
    done     = (state_q == DONE);
    err      = (state_q == ERR);
    cpu_rst  = (state_q != DONE);
  end

  always_comb begin
    len_lo_d   = len_lo_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (start_ok) begin
      word_cnt_d = '0;
      n_d        = '0;
    end
    if (accept && state_q == LEN0) len_lo_d = rx_data;
    if (accept && state_q == LEN1) n_d = len_full;
    // The write is registered so we, waddr and wdata all appear together one cycle later.
    if (asm_word_valid) begin
      we_d       = 1'b1;
      waddr_d    = {word_cnt_q[IMEM_W-3:0], 2'b00};
      wdata_d    = asm_word;
      word_cnt_d = word_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo_q   <= '0;
      n_q        <= '0;
      word_cnt_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      len_lo_q   <= len_lo_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized self-checking bench for imem_boot_ctrl against a stream-level reference model.
module tb_imem_boot_ctrl;

  localparam int IMEM_W = 13;
  localparam int CAP    = 1 << (IMEM_W - 2);
  localparam int RV_W   = 2 + IMEM_W + 32 + 4 + IMEM_W - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_ready;
  logic              we;
  logic [IMEM_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;
  logic [IMEM_W-2:0] word_cnt;

  imem_boot_ctrl #(.IMEM_W(IMEM_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .rx_ready(rx_ready),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IMEM_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         obs_q[$];
  wr_t         exp_q[$];
  logic [7:0]  stream_q[$];
  logic [31:0] words_q[$];
  bit          exp_done, exp_err;
  int          exp_cnt;
  bit          timeout;
  int          n_checks = 0;
  int          n_pass   = 0;

  logic [RV_W-1:0] rv_exp;
  assign rv_exp = {1'b0, 1'b0, {IMEM_W{1'b0}}, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, {(IMEM_W-1){1'b0}}};

  always @(negedge clk) begin
    if (we === 1'b1) obs_q.push_back('{addr: waddr, data: wdata});
  end

  // Reference model: words_q -> byte stream, expected writes and final verdict.
  function automatic void model_load(input int n, input bit corrupt);
    logic [7:0] s;
    logic [7:0] b;
    stream_q.delete();
    exp_q.delete();
    stream_q.push_back(n[7:0]);
    stream_q.push_back(n[15:8]);
    if (n > CAP) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      exp_cnt  = 0;
      return;
    end
    s = 8'h00;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = words_q[i][8*k +: 8];
        stream_q.push_back(b);
        s = s + b;
      end
      exp_q.push_back('{addr: IMEM_W'(i * 4), data: words_q[i]});
    end
    stream_q.push_back(corrupt ? s + 8'h01 : s);
    exp_done = !corrupt;
    exp_err  = corrupt;
    exp_cnt  = n;
  endfunction

  function automatic int count_write_diffs();
    int d = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size()
                                           : exp_q.size() - obs_q.size();
    int m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      if (obs_q[i].addr !== exp_q[i].addr || obs_q[i].data !== exp_q[i].data) d++;
    return d;
  endfunction

  // Pulses start, then offers stream bytes with random stalls; optionally re-pulses start at byte start_at.
  task automatic run_load(input int stall_pct, input int start_at, input int max_bytes);
    int guard;
    timeout = 1'b0;
    obs_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < stream_q.size() && i < max_bytes; i++) begin
      while ($urandom_range(99) < stall_pct) begin
        rx_valid = 1'b0;
        @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = stream_q[i];
      start    = (i == start_at);
      guard    = 0;
      while (rx_ready !== 1'b1 && guard < 50) begin
        @(negedge clk);
        start = 1'b0;
        guard++;
      end
      if (guard >= 50) begin
        timeout  = 1'b1;
        rx_valid = 1'b0;
        break;
      end
      @(negedge clk);
      start    = 1'b0;
      rx_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({rx_ready, we, waddr, wdata, cpu_rst, busy, done, err, word_cnt} !== rv_exp)
      $display("FAIL reset_values got %h want %h",
               {rx_ready, we, waddr, wdata, cpu_rst, busy, done, err, word_cnt}, rv_exp);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (rx_ready !== 1'b0 || busy !== 1'b0) $display("FAIL idle_quiet rx_ready=%b busy=%b want 0 0", rx_ready, busy);
    else n_pass++;
  endtask

  task automatic test_nominal();
    words_q = '{32'h0000_0013, 32'h0010_0093};
    model_load(2, 1'b0);
    run_load(0, -1, 1 << 30);
    n_checks++;
    if (timeout || done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b0)
      $display("FAIL nominal_result done=%b err=%b cpu_rst=%b to=%b want 1 0 0 0", done, err, cpu_rst, timeout);
    else n_pass++;
    n_checks++;
    if (word_cnt !== 12'd2) $display("FAIL nominal_word_cnt got %0d want 2", word_cnt);
    else n_pass++;
    n_checks++;
    if (obs_q.size() != 2) $display("FAIL nominal_write_count got %0d want 2", obs_q.size());
    else if (obs_q[0].addr !== 13'h000 || obs_q[0].data !== 32'h0000_0013 ||
             obs_q[1].addr !== 13'h004 || obs_q[1].data !== 32'h0010_0093)
      $display("FAIL nominal_writes got %h/%h %h/%h want 000/00000013 004/00100093",
               obs_q[0].addr, obs_q[0].data, obs_q[1].addr, obs_q[1].data);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || we !== 1'b0) $display("FAIL done_sticky done=%b busy=%b we=%b want 1 0 0", done, busy, we);
    else n_pass++;
  endtask

  task automatic test_bad_chk();
    words_q = '{32'h0000_0013, 32'h0010_0093};
    model_load(2, 1'b1);
    n_checks++;
    if (stream_q[10] !== 8'hB7) $display("FAIL bad_chk_stream got %h want b7", stream_q[10]);
    else n_pass++;
    run_load(0, -1, 1 << 30);
    n_checks++;
    if (timeout || err !== 1'b1 || done !== 1'b0 || cpu_rst !== 1'b1)
      $display("FAIL bad_chk_result err=%b done=%b cpu_rst=%b want 1 0 1", err, done, cpu_rst);
    else n_pass++;
    n_checks++;
    if (count_write_diffs() != 0) $display("FAIL bad_chk_writes diffs=%0d want 0 (got %0d writes)", count_write_diffs(), obs_q.size());
    else n_pass++;
  endtask

  task automatic test_oversize();
    words_q.delete();
    model_load(CAP + 1, 1'b0);
    run_load(0, -1, 1 << 30);
    n_checks++;
    if (timeout || err !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b0)
      $display("FAIL oversize_result err=%b done=%b rx_ready=%b want 1 0 0", err, done, rx_ready);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_q.size() != 0 || rx_ready !== 1'b0) $display("FAIL oversize_no_write writes=%0d rx_ready=%b want 0 0", obs_q.size(), rx_ready);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    words_q.delete();
    model_load(0, 1'b0);
    run_load(0, -1, 1 << 30);
    n_checks++;
    if (timeout || done !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b0 || word_cnt !== '0 || obs_q.size() != 0)
      $display("FAIL zero_len done=%b err=%b cpu_rst=%b cnt=%0d writes=%0d want 1 0 0 0 0",
               done, err, cpu_rst, word_cnt, obs_q.size());
    else n_pass++;
  endtask

  task automatic test_stalls_start_busy();
    words_q = '{32'h0000_0013, 32'h0010_0093};
    model_load(2, 1'b0);
    run_load(40, 5, 1 << 30);
    n_checks++;
    if (timeout || done !== exp_done || err !== exp_err || word_cnt !== (IMEM_W-1)'(exp_cnt))
      $display("FAIL stall_result done=%b err=%b cnt=%0d want %b %b %0d", done, err, word_cnt, exp_done, exp_err, exp_cnt);
    else n_pass++;
    n_checks++;
    if (count_write_diffs() != 0) $display("FAIL stall_writes diffs=%0d want 0", count_write_diffs());
    else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    words_q = '{32'h0000_0013, 32'h0010_0093};
    model_load(2, 1'b0);
    run_load(0, -1, 5);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL mid_load_busy got %b want 1", busy);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rx_ready, we, waddr, wdata, cpu_rst, busy, done, err, word_cnt} !== rv_exp)
      $display("FAIL mid_reset_values got %h want %h",
               {rx_ready, we, waddr, wdata, cpu_rst, busy, done, err, word_cnt}, rv_exp);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    run_load(0, -1, 1 << 30);
    n_checks++;
    if (timeout || done !== 1'b1 || count_write_diffs() != 0)
      $display("FAIL reload_after_reset done=%b diffs=%0d want 1 0", done, count_write_diffs());
    else n_pass++;
  endtask

  task automatic test_capacity();
    words_q.delete();
    for (int i = 0; i < CAP; i++) words_q.push_back($urandom);
    model_load(CAP, 1'b0);
    run_load(0, -1, 1 << 30);
    n_checks++;
    if (timeout || done !== 1'b1 || word_cnt !== (IMEM_W-1)'(CAP))
      $display("FAIL capacity_result done=%b cnt=%0d want 1 %0d", done, word_cnt, CAP);
    else n_pass++;
    n_checks++;
    if (obs_q.size() == 0 || obs_q[obs_q.size()-1].addr !== 13'h1FFC || count_write_diffs() != 0)
      $display("FAIL capacity_writes count=%0d diffs=%0d want %0d 0 last_addr 1ffc", obs_q.size(), count_write_diffs(), CAP);
    else n_pass++;
  endtask

  task automatic test_random_loads();
    int n;
    bit corrupt;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(8);
      corrupt = ($urandom_range(2) == 0);
      words_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back($urandom);
      model_load(n, corrupt);
      run_load(30, -1, 1 << 30);
      n_checks++;
      if (timeout || done !== exp_done || err !== exp_err || cpu_rst !== !exp_done ||
          word_cnt !== (IMEM_W-1)'(exp_cnt) || count_write_diffs() != 0)
        $display("FAIL random_load_%0d done=%b err=%b cnt=%0d diffs=%0d want %b %b %0d 0",
                 t, done, err, word_cnt, count_write_diffs(), exp_done, exp_err, exp_cnt);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_bad_chk();
    test_oversize();
    test_zero_len();
    test_stalls_start_busy();
    test_reset_mid_load();
    test_capacity();
    test_random_loads();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
